alu_share_arb: RTL and testbench
================================

# alu_share_arb

Shares one combinational ALU instance between NREQ requesters (e.g. execute stage, address-generation, CSR read-modify-write) using a round-robin arbiter and a single-entry registered response stage. Each cycle at most one request is granted, evaluated by the ALU, and its result registered with the requester ID. The response stage supports valid/ready backpressure at full throughput. The block sits between the core's requesters and the shared ALU, which it instantiates internally.

## Interface
- XLEN, 32, operand/result width
- ALUOP_W, 4, ALU opcode width; bits [2:0] = RV32I funct3, bit 3 = alternate (SUB/SRA)
- NREQ, 2, number of requesters (≥2)
- IDW, $clog2(NREQ), requester ID width (derived, not overridden)

- clk  in  1  clock; all state updates on rising edge
- rst_b  in  1  asynchronous active-low reset
- req_valid  in  NREQ  request valid, bit i = requester i
- req_ready  out  NREQ  request accepted this cycle, one-hot or zero
- req_opcode  in  NREQ*ALUOP_W  opcode, requester i at [i*ALUOP_W +: ALUOP_W]
- req_src1  in  NREQ*XLEN  operand 1, requester i at [i*XLEN +: XLEN]
- req_src2  in  NREQ*XLEN  operand 2, same slicing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  index of requester that owns rsp_result
- rsp_result  out  XLEN  ALU result

## Operation
- Requester rule: once req_valid[i] rises it stays high with stable opcode/operands until req_ready[i]; req_valid must not depend combinationally on req_ready.
- State: rr_ptr (IDW bits, next-highest-priority index), out_valid, out_id, out_result.
- Arbitration (combinational): scan i = rr_ptr, rr_ptr+1, … mod NREQ; first i with req_valid[i] is grant index g. No valid → no grant.
- can_accept = ~out_valid | rsp_ready.
- req_ready[g] = can_accept & rst_b deasserted; all other bits 0. Handshake = req_valid[g] & req_ready[g].
- ALU inputs are muxed from slice g; on handshake: out_result ← ALU result, out_id ← g, out_valid ← 1, rr_ptr ← (g+1) mod NREQ (wrap from NREQ-1 to 0).
- No handshake and rsp_valid & rsp_ready: out_valid ← 0; out_result/out_id hold.
- Simultaneous drain and accept: new entry replaces old, out_valid stays 1.
- Stalled (out_valid & ~rsp_ready): req_ready all 0, rr_ptr, output fields hold.
- Opcode decoding is the ALU's; arbiter passes opcode unchanged. Results are XLEN-bit, carry discarded; SLT/SLTU return 0 or 1.
- Fairness: any requester holding valid is granted within NREQ accepted handshakes.

## Timing
- Reset (rst_b low, async): rsp_valid=0, rsp_id=0, rsp_result=0, rr_ptr=0, req_ready=0 immediately. First grant possible the first rising edge after rst_b high.
- Latency: handshake at edge T → rsp_valid/rsp_result at T (visible in cycle after T), i.e. 1 cycle.
- Throughput: one result per cycle with rsp_ready held high.
- rsp_valid, rsp_id, rsp_result registered; req_ready combinational from req_valid, out_valid, rsp_ready, rr_ptr.
- Reset mid-operation: pending response dropped, no retry; requesters must re-present after reset.

## Test plan
- Reset then single request: requester 0 ADD (opcode 0000) 5+7 with rsp_ready=1 → req_ready=01 same cycle, next cycle rsp_valid=1, rsp_id=0, rsp_result=12; rr_ptr=1.
- Round-robin: both valid continuously, requester 0 SUB (1000) 10-3, requester 1 SRA (1101) 0x80000000>>4, rsp_ready=1 → grants alternate 0,1,0,1; results 7 and 0xF8000000; rsp_id toggles every cycle.
- Backpressure: rsp_ready=0 for 3 cycles with held response SLTU (0011) 1 vs 0xFFFFFFFF → rsp_valid=1, rsp_result=1 stable, req_ready=00; on rsp_ready=1 next request accepted same cycle, no response dropped or duplicated.
- Pointer wrap (NREQ=4): grant requester 3 then only requester 0 valid → g=0, rr_ptr goes 0→1; with 1 and 3 valid and rr_ptr=2 → requester 3 wins first.
- Simultaneous drain/accept and idle: SLT (0010) -1 vs 1 held, rsp_ready=1 with new XOR (0100) 0xF0F0^0x0FF0 → rsp_valid stays 1, results 1 then 0xFF00; no valid → rsp_valid drops after drain.
- Async reset mid-stall: assert rst_b low between edges while rsp_valid=1 → rsp_valid, rsp_id, rsp_result go 0 without a clock edge; rr_ptr=0 after release.

Source files
------------

// File: rtl/alu_share_arb_if.sv
// Request/response bundle between the requesters and the shared-ALU arbiter.
// Requester i occupies bit i of the valid/ready vectors and slice i of the packed buses.
interface alu_share_arb_if #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4,
    parameter int NREQ    = 2
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*ALUOP_W-1:0] req_opcode;
    logic [NREQ*XLEN-1:0]    req_src1;
    logic [NREQ*XLEN-1:0]    req_src2;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [IDW-1:0]          rsp_id;
    logic [XLEN-1:0]         rsp_result;

    modport master (
        output req_valid,
        output req_opcode,
        output req_src1,
        output req_src2,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_result
    );

    modport slave (
        input  req_valid,
        input  req_opcode,
        input  req_src1,
        input  req_src2,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_id,
        output rsp_result
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbitration of NREQ requesters onto one shared combinational ALU,
// with a single registered response slot that drains under valid/ready backpressure.
module alu_share_arb #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4,
    parameter int NREQ    = 2
) (
    input logic            clk,
    input logic            rst_b,
    alu_share_arb_if.slave bus
);
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IDW1 = IDW + 1;
    localparam int SHW  = $clog2(XLEN);

    logic [IDW-1:0]     r_rr_ptr;
    logic               r_out_valid;
    logic [IDW-1:0]     r_out_id;
    logic [XLEN-1:0]    r_out_result;

    logic               w_gnt_found;
    logic [IDW-1:0]     w_gnt_idx;
    logic [IDW1-1:0]    w_sum;
    logic [IDW-1:0]     w_scan;
    logic [IDW-1:0]     w_ptr_next;
    logic               w_can_accept;
    logic               w_accept;
    logic [ALUOP_W-1:0] w_op;
    logic [XLEN-1:0]    w_src1;
    logic [XLEN-1:0]    w_src2;
    logic [SHW-1:0]     w_shamt;
    logic [XLEN-1:0]    w_alu_result;

    // Scan starting at the pointer; the extra sum bit lets non-power-of-two NREQ wrap correctly.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_sum       = '0;
        w_scan      = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + IDW1'(k);
            if (w_sum >= IDW1'(NREQ)) begin
                w_sum = w_sum - IDW1'(NREQ);
            end
            w_scan = w_sum[IDW-1:0];
            if (!w_gnt_found && bus.req_valid[w_scan]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_scan;
            end
        end
    end

    always_comb begin
        w_can_accept = !r_out_valid || bus.rsp_ready;
        w_accept     = w_gnt_found && w_can_accept && rst_b;
        w_ptr_next   = (int'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + 1'b1;
        bus.req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = w_accept && (w_gnt_idx == IDW'(i));
        end
    end

    always_comb begin
        w_op   = '0;
        w_src1 = '0;
        w_src2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == IDW'(i)) begin
                w_op   = bus.req_opcode[i*ALUOP_W +: ALUOP_W];
                w_src1 = bus.req_src1[i*XLEN +: XLEN];
                w_src2 = bus.req_src2[i*XLEN +: XLEN];
            end
        end
    end

    // RV32I-style ALU: op[2:0] is funct3, op[3] selects SUB / SRA.
    always_comb begin
        w_shamt      = w_src2[SHW-1:0];
        w_alu_result = '0;
        case (w_op[2:0])
            3'b000:  w_alu_result = w_op[3] ? (w_src1 - w_src2) : (w_src1 + w_src2);
            3'b001:  w_alu_result = w_src1 << w_shamt;
            3'b010:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_src1) < $signed(w_src2))};
            3'b011:  w_alu_result = {{(XLEN-1){1'b0}}, (w_src1 < w_src2)};
            3'b100:  w_alu_result = w_src1 ^ w_src2;
            3'b101:  w_alu_result = w_op[3] ? XLEN'($signed(w_src1) >>> w_shamt)
                                            : (w_src1 >> w_shamt);
            3'b110:  w_alu_result = w_src1 | w_src2;
            3'b111:  w_alu_result = w_src1 & w_src2;
            default: w_alu_result = '0;
        endcase
    end

    // A new accept overwrites the slot even while it drains, so throughput stays one per cycle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_rr_ptr     <= '0;
            r_out_valid  <= 1'b0;
            r_out_id     <= '0;
            r_out_result <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid  <= 1'b1;
                r_out_id     <= w_gnt_idx;
                r_out_result <= w_alu_result;
                r_rr_ptr     <= w_ptr_next;
            end else if (bus.rsp_ready) begin
                r_out_valid  <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid  = r_out_valid;
    assign bus.rsp_id     = r_out_id;
    assign bus.rsp_result = r_out_result;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_b)
        $onehot0(bus.req_ready));

    a_stall_holds: assert property (@(posedge clk) disable iff (!rst_b)
        (bus.rsp_valid && !bus.rsp_ready) |=>
            (bus.rsp_valid && $stable(bus.rsp_result) && $stable(bus.rsp_id)));
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb (NREQ=4): the driver pushes hand-computed responses
// into a scoreboard queue and an independent monitor pops them on each response handshake.
module tb_alu_share_arb;
    localparam int XLEN    = 32;
    localparam int ALUOP_W = 4;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;

    logic clk;
    logic rst_b;

    alu_share_arb_if #(.XLEN(XLEN), .ALUOP_W(ALUOP_W), .NREQ(NREQ)) bus ();

    alu_share_arb #(.XLEN(XLEN), .ALUOP_W(ALUOP_W), .NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [XLEN-1:0] res;
    } rsp_t;

    rsp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        bus.req_opcode[i*ALUOP_W +: ALUOP_W] = op;
        bus.req_src1[i*XLEN +: XLEN]         = a;
        bus.req_src2[i*XLEN +: XLEN]         = b;
    endtask

    // Drive valids/ready, check the combinational grant, and queue the expected response.
    task automatic apply(input logic [NREQ-1:0] v, input logic rr,
                         input logic [NREQ-1:0] exp_rdy, input logic [XLEN-1:0] exp_res);
        rsp_t e;
        bus.req_valid = v;
        bus.rsp_ready = rr;
        #2;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        if (exp_rdy != '0) begin
            e.res = exp_res;
            e.id  = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (exp_rdy[i]) e.id = IDW'(i);
            end
            sb_q.push_back(e);
        end
    endtask

    task automatic chk_out(input logic v, input logic [IDW-1:0] id, input logic [XLEN-1:0] res);
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(v));
        chk("rsp_id", 64'(bus.rsp_id), 64'(id));
        chk("rsp_result", 64'(bus.rsp_result), 64'(res));
    endtask

    // Monitor: every response handshake must match the oldest queued expectation.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_b && bus.rsp_valid && bus.rsp_ready) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got id %0d result %h, expected none (t=%0t)",
                             bus.rsp_id, bus.rsp_result, $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_rsp_id", 64'(bus.rsp_id), 64'(e.id));
                    chk("sb_rsp_result", 64'(bus.rsp_result), 64'(e.res));
                end
            end
        end
    end

    initial begin
        rst_b          = 1'b1;
        bus.req_valid  = '0;
        bus.rsp_ready  = 1'b0;
        bus.req_opcode = '0;
        bus.req_src1   = '0;
        bus.req_src2   = '0;
        #1 rst_b = 1'b0;

        // Reset: outputs cleared, requests not accepted.
        next_cycle();
        set_req(0, 4'b0000, 32'd5, 32'd7);
        apply(4'b0001, 1'b1, 4'b0000, '0);
        chk_out(1'b0, '0, '0);

        // Release and single ADD.
        next_cycle();
        rst_b = 1'b1;
        apply(4'b0001, 1'b1, 4'b0001, 32'd12);

        // Round-robin between SUB (req0) and SRA (req1); pointer is 1 after the ADD.
        next_cycle();
        set_req(0, 4'b1000, 32'd10, 32'd3);
        set_req(1, 4'b1101, 32'h8000_0000, 32'd4);
        apply(4'b0011, 1'b1, 4'b0010, 32'hF800_0000);
        next_cycle();
        apply(4'b0011, 1'b1, 4'b0001, 32'd7);
        next_cycle();
        apply(4'b0011, 1'b1, 4'b0010, 32'hF800_0000);
        next_cycle();
        apply(4'b0011, 1'b1, 4'b0001, 32'd7);

        // Backpressure on SLTU result.
        next_cycle();
        set_req(1, 4'b0011, 32'd1, 32'hFFFF_FFFF);
        apply(4'b0010, 1'b1, 4'b0010, 32'd1);
        next_cycle();
        set_req(0, 4'b0000, 32'd100, 32'd200);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) next_cycle();
            apply(4'b0001, 1'b0, 4'b0000, '0);
            chk_out(1'b1, 2'd1, 32'd1);
        end
        next_cycle();
        apply(4'b0001, 1'b1, 4'b0001, 32'd300);

        // Pointer wrap: req3 then req0, then 1/3 contention from pointer 2.
        next_cycle();
        set_req(3, 4'b0110, 32'h0F, 32'hF0);
        apply(4'b1000, 1'b1, 4'b1000, 32'hFF);
        next_cycle();
        set_req(0, 4'b0111, 32'hFF00_FF00, 32'h0FF0_0FF0);
        apply(4'b0001, 1'b1, 4'b0001, 32'h0F00_0F00);
        next_cycle();
        set_req(1, 4'b0001, 32'd1, 32'd31);
        apply(4'b0011, 1'b1, 4'b0010, 32'h8000_0000);
        next_cycle();
        set_req(3, 4'b0101, 32'hF000_0000, 32'd28);
        apply(4'b1011, 1'b1, 4'b1000, 32'hF);
        next_cycle();
        apply(4'b1011, 1'b1, 4'b0001, 32'h0F00_0F00);
        next_cycle();
        apply(4'b1010, 1'b1, 4'b0010, 32'h8000_0000);

        // Simultaneous drain/accept, then idle drain.
        next_cycle();
        set_req(2, 4'b0010, 32'hFFFF_FFFF, 32'd1);
        apply(4'b0100, 1'b1, 4'b0100, 32'd1);
        next_cycle();
        apply(4'b0000, 1'b0, 4'b0000, '0);
        chk_out(1'b1, 2'd2, 32'd1);
        next_cycle();
        set_req(0, 4'b0100, 32'h0000_F0F0, 32'h0000_0FF0);
        apply(4'b0001, 1'b1, 4'b0001, 32'h0000_FF00);
        next_cycle();
        apply(4'b0000, 1'b1, 4'b0000, '0);
        chk_out(1'b1, 2'd0, 32'h0000_FF00);
        next_cycle();
        apply(4'b0000, 1'b1, 4'b0000, '0);
        chk("rsp_valid_idle", 64'(bus.rsp_valid), 64'd0);

        // Async reset while a response is stalled.
        next_cycle();
        set_req(1, 4'b0000, 32'hFFFF_FFFF, 32'd2);
        apply(4'b0010, 1'b1, 4'b0010, 32'd1);
        next_cycle();
        apply(4'b0000, 1'b0, 4'b0000, '0);
        chk_out(1'b1, 2'd1, 32'd1);
        rst_b = 1'b0;
        if (sb_q.size() > 0) sb_q.delete(sb_q.size() - 1);
        #1;
        chk_out(1'b0, '0, '0);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        #1;
        chk("req_ready_in_reset", 64'(bus.req_ready), 64'd0);

        // Pointer restarts at 0: with 1 and 2 valid, 1 wins.
        next_cycle();
        rst_b = 1'b1;
        set_req(2, 4'b0010, 32'hFFFF_FFFF, 32'd1);
        apply(4'b0110, 1'b1, 4'b0010, 32'd1);
        next_cycle();
        apply(4'b0100, 1'b1, 4'b0100, 32'd1);
        next_cycle();
        apply(4'b0000, 1'b1, 4'b0000, '0);
        repeat (3) next_cycle();
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
